// File: rtl/imm_pkg.sv
// Shared constants for the pipelined immediate generator: one-hot type bit
// positions, the type-vector width, FIFO occupancy states and a parameter
// legality helper.
package imm_pkg;

  localparam int TYPE_W = 8;

  // Bit positions inside the one-hot instruction-type vector.
  localparam int TYPE_R     = 7;
  localparam int TYPE_I     = 6;
  localparam int TYPE_S     = 5;
  localparam int TYPE_B     = 4;
  localparam int TYPE_U     = 3;
  localparam int TYPE_J     = 2;
  localparam int TYPE_CSR   = 1;
  localparam int TYPE_SHAMT = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PART,
    OCC_FULL
  } occ_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: decodes the one-hot type and produces
// the sign- or zero-extended immediate. Zero or multi-hot types give imm=0
// and raise illegal.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]       inst,
  input  logic [TYPE_W-1:0] typ,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];

  // A 32-bit signed value widened to XLEN; the size cast of a signed
  // operand replicates the sign bit, so the same code serves XLEN=32 and 64.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Select the immediate format named by the single set type bit.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    imm     = '0;
    illegal = !$onehot(typ);
    if (!illegal) begin
      if (typ[TYPE_I])
        imm = sext32({{20{inst[31]}}, inst[31:20]});
      else if (typ[TYPE_S])
        imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
      else if (typ[TYPE_B])
        imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      else if (typ[TYPE_U])
        imm = sext32({inst[31:12], 12'b0});
      else if (typ[TYPE_J])
        imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      else if (typ[TYPE_CSR])
        imm = XLEN'(inst[19:15]);
      else if (typ[TYPE_SHAMT])
        imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
      // R-type keeps the zero default.
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: extracts the immediate, adds it to the pc
// for a branch/jump target and queues {imm, target, illegal} in a small FIFO
// so decode stalls do not back up fetch. Outputs come only from FIFO storage.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2,
  parameter int TYPE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [TYPE_W-1:0] in_type,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_target,
  output logic              out_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (!xlen_legal(XLEN) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (TYPE_W != imm_pkg::TYPE_W)) begin : g_bad_params
    $fatal(1, "imm_gen_pipe: illegal XLEN/DEPTH/TYPE_W");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  logic [XLEN-1:0]  ext_imm;
  logic             ext_illegal;
  entry_t           wr_entry;
  entry_t           head;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  occ_e             occ;
  logic             push;
  logic             pop;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .inst    (in_inst),
    .typ     (in_type),
    .imm     (ext_imm),
    .illegal (ext_illegal)
  );

  // Illegal types extract imm=0, so the target falls back to the pc itself.
  assign wr_entry = '{imm: ext_imm, target: in_pc + ext_imm, illegal: ext_illegal};

  // Classify occupancy from the entry count.
  always_comb begin
    occ = OCC_PART;
    if (count == '0)
      occ = OCC_EMPTY;
    else if (count == CNT_W'(DEPTH))
      occ = OCC_FULL;
  end

  assign in_ready  = (occ != OCC_FULL);
  assign out_valid = (occ != OCC_EMPTY);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Pointer and count update; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage write.
  // NOTE: storage has no reset; stale contents are never observable because outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head        = mem[rd_ptr];
  assign out_imm     = out_valid ? head.imm     : '0;
  assign out_target  = out_valid ? head.target  : '0;
  assign out_illegal = out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed cases plus a randomized run
// compared against a queue-based reference model; a second XLEN=64 instance
// covers the 64-bit sign/zero extension cases.
module tb_imm_gen_pipe;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [7:0]  in_type;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [31:0] out_target;
  logic        out_illegal;

  logic        w_flush;
  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_in_inst;
  logic [7:0]  w_in_type;
  logic [63:0] w_in_pc;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [63:0] w_out_imm;
  logic [63:0] w_out_target;
  logic        w_out_illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] target;
    logic        ill;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TYPE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_type(in_type), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(4), .TYPE_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inst(w_in_inst),
    .in_type(w_in_type), .in_pc(w_in_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_imm(w_out_imm),
    .out_target(w_out_target), .out_illegal(w_out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Two's-complement value of the low 'bits' bits of v.
  function automatic longint sx(input longint v, input int bits);
    longint m = v & ((64'sd1 <<< bits) - 1);
    if (m >= (64'sd1 <<< (bits - 1))) m = m - (64'sd1 <<< bits);
    return m;
  endfunction

  // Reference immediate from the instruction-format rules, truncated to xlen.
  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [7:0] ty,
                                          input int xlen, output logic ill);
    longint u = longint'(inst);
    longint v = 0;
    ill = ($countones(ty) != 1);
    if (!ill) begin
      if (ty == 8'h40)      v = sx(u >> 20, 12);
      else if (ty == 8'h20) v = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      else if (ty == 8'h10) v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                                   (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      else if (ty == 8'h08) v = sx(u & 64'hFFFF_F000, 32);
      else if (ty == 8'h04) v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                                   (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      else if (ty == 8'h02) v = (u >> 15) & 31;
      else if (ty == 8'h01) v = (u >> 20) & ((xlen == 64) ? 63 : 31);
    end
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic [7:0] ty,
                       input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid  = v;
    in_inst   = inst;
    in_type   = ty;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance one clock, updating the model from the handshake rules.
  task automatic tick();
    bit   push;
    bit   pop;
    exp_t e;
    logic ill;
    logic [63:0] im;
    push = in_valid && (q.size() < DEPTH) && !flush;
    pop  = (q.size() != 0) && out_ready && !flush;
    im   = ref_imm(in_inst, in_type, 32, ill);
    e.imm    = im[31:0];
    e.target = in_pc + im[31:0];
    e.ill    = ill;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".in_ready"},  in_ready,  q.size() < DEPTH);
    check({tag, ".out_valid"}, out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check({tag, ".imm"},     out_imm,     q[0].imm);
      check({tag, ".target"},  out_target,  q[0].target);
      check({tag, ".illegal"}, out_illegal, q[0].ill);
    end else begin
      check({tag, ".imm0"},     out_imm,     0);
      check({tag, ".target0"},  out_target,  0);
      check({tag, ".illegal0"}, out_illegal, 0);
    end
  endtask

  initial begin
    logic        ill;
    logic [63:0] im;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    w_flush = 0; w_in_valid = 0; w_in_inst = 0; w_in_type = 0; w_in_pc = 0; w_out_ready = 1;
    #12;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.imm", out_imm, 0);
    check("rst.target", out_target, 0);
    check("rst.illegal", out_illegal, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // I-type
    drive(1, 32'hFFF0_0093, 8'h40, 32'h100, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    check("i.imm", out_imm, 32'hFFFF_FFFF);
    check("i.target", out_target, 32'h0000_00FF);
    check("i.illegal", out_illegal, 0);
    check_state("i");
    drive(0, 0, 0, 0, 1, 0); tick(); check_state("i_pop");

    // B-type and wrap-around target
    drive(1, 32'hFE00_0EE3, 8'h10, 32'h200, 0, 0); tick();
    check("b.imm", out_imm, 32'hFFFF_FFFC);
    check("b.target", out_target, 32'h1FC);
    drive(1, 32'h0000_0463, 8'h10, 32'hFFFF_FFFC, 1, 0); tick();
    check("wrap.imm", out_imm, 32'h8);
    check("wrap.target", out_target, 32'h4);
    check_state("wrap");
    drive(0, 0, 0, 0, 1, 0); tick(); check_state("wrap_pop");

    // Illegal types: multi-hot then zero; second fills the FIFO
    drive(1, 32'hFFF0_0093, 8'h18, 32'h40, 0, 0); tick();
    drive(1, 32'h1234_5678, 8'h00, 32'h40, 0, 0); tick();
    check("full.in_ready", in_ready, 0);
    check("ill.illegal", out_illegal, 1);
    check("ill.imm", out_imm, 0);
    check("ill.target", out_target, 32'h40);
    drive(0, 0, 0, 0, 1, 0); tick();
    check("ill0.illegal", out_illegal, 1);
    check("ill0.imm", out_imm, 0);
    check("ill0.target", out_target, 32'h40);
    tick(); check_state("ill_drain");

    // Backpressure: three back-to-back pushes with consumer stalled
    drive(1, 32'h0010_0093, 8'h40, 32'h1000, 0, 0); tick(); check_state("bp1");
    drive(1, 32'h0020_0093, 8'h40, 32'h2000, 0, 0); tick();
    check("bp.in_ready_after2", in_ready, 0);
    drive(1, 32'h0030_0093, 8'h40, 32'h3000, 0, 0); tick();
    check("bp.held_head", out_target, 32'h1001);
    check_state("bp3");
    drive(1, 32'h0030_0093, 8'h40, 32'h3000, 1, 0); tick();
    check("bp.pop1_head", out_target, 32'h2002);
    check("bp.ready_after_pop", in_ready, 1);
    tick();
    check("bp.third_head", out_target, 32'h3003);
    check_state("bp5");
    drive(0, 0, 0, 0, 1, 0); tick(); check_state("bp_drain");

    // Flush with two entries and a same-cycle input
    drive(1, 32'h0040_0093, 8'h40, 32'h10, 0, 0); tick();
    drive(1, 32'h0050_0093, 8'h40, 32'h20, 0, 0); tick();
    drive(1, 32'h0060_0093, 8'h40, 32'h30, 1, 1); tick();
    check("flush.out_valid", out_valid, 0);
    check("flush.in_ready", in_ready, 1);
    drive(0, 0, 0, 0, 1, 0); tick();
    check("flush.no_ghost", out_valid, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ty;
      ty = ($urandom_range(9) < 8) ? 8'(1 << $urandom_range(7)) : 8'($urandom);
      drive($urandom_range(3) != 0, $urandom, ty, $urandom,
            $urandom_range(2) != 0, $urandom_range(24) == 0);
      tick();
      check_state("rand");
    end

    // Asynchronous reset mid-stream
    drive(1, 32'h0070_0093, 8'h40, 32'h50, 0, 0); tick();
    drive(1, 32'h0080_0093, 8'h40, 32'h60, 0, 0); tick();
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    check("arst.out_valid", out_valid, 0);
    check("arst.imm", out_imm, 0);
    check("arst.target", out_target, 0);
    check("arst.in_ready", in_ready, 1);
    drive(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_state("arst_after");

    // XLEN=64: lui and 6-bit shamt
    w_in_valid = 1; w_in_inst = 32'h8000_00B7; w_in_type = 8'h08; w_in_pc = 64'h1000;
    @(posedge clk); #1;
    w_in_valid = 0;
    im = ref_imm(32'h8000_00B7, 8'h08, 64, ill);
    check("x64.lui.imm", w_out_imm, 64'hFFFF_FFFF_8000_0000);
    check("x64.lui.model", w_out_imm, im);
    check("x64.lui.target", w_out_target, 64'hFFFF_FFFF_8000_1000);
    @(posedge clk); #1;
    check("x64.empty", w_out_valid, 0);
    w_in_valid = 1; w_in_inst = 32'h03F0_D093; w_in_type = 8'h01; w_in_pc = 64'h0;
    @(posedge clk); #1;
    w_in_valid = 0;
    check("x64.shamt.imm", w_out_imm, 64'h3F);
    check("x64.shamt.illegal", w_out_illegal, 0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
